// File: rtl/edulent_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : edulent_pkg
//  Description : Shared definitions for the transfer datapath: data width,
//                register-transfer command encoding and the memory
//                handshake state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package edulent_pkg;

  localparam int DATA_W = 8;

  // Register-transfer commands, one per encoding of the 4-bit command bus.
  typedef enum logic [3:0] {
    CMD_NOP     = 4'h0,  // no operation
    CMD_MA_PC   = 4'h1,  // MA <= PC
    CMD_MEM_RD  = 4'h2,  // start memory read at MA
    CMD_IR_MD   = 4'h3,  // IR <= MD
    CMD_MA_MD   = 4'h4,  // MA <= MD
    CMD_ACC_MD  = 4'h5,  // A/AP <= MD
    CMD_MA_AP   = 4'h6,  // MA <= AP
    CMD_MA_SP   = 4'h7,  // MA <= SP
    CMD_MD_ACC  = 4'h8,  // MD <= A/AP
    CMD_MEM_WR  = 4'h9,  // start memory write of MD at MA
    CMD_ACC_ALU = 4'hA,  // A/AP <= ALU result
    CMD_PC_MD   = 4'hB,  // PC <= MD
    CMD_A_IN    = 4'hC,  // A <= input port
    CMD_OUT_A   = 4'hD,  // output port <= A, strobe valid
    CMD_PC_AP   = 4'hE,  // PC <= AP
    CMD_MD_PC   = 4'hF   // MD <= PC
  } transfer_cmd_t;

  // Memory handshake states.
  typedef enum logic [1:0] {
    MEM_IDLE    = 2'd0,
    MEM_RD_WAIT = 2'd1,
    MEM_WR_WAIT = 2'd2
  } mem_state_t;

endpackage : edulent_pkg
`default_nettype wire

// File: rtl/mem_handshake.sv
`default_nettype none
// ============================================================================
//  Module      : mem_handshake
//  Description : Req/ack memory sequencer. A start request in IDLE latches
//                the address (and write data) and raises the request until
//                the memory acknowledges. Ack outside a wait state is ignored.
//  Ports       : i_clk, i_rstn      - clock, async active-low reset
//                i_start_rd/_wr     - begin a read / write (sampled in IDLE)
//                i_addr, i_wdata    - address and write data to latch
//                i_ack              - memory completes the request
//                o_req, o_we        - registered request / write-enable
//                o_addr, o_wdata    - latched address / write data
//                o_rd_done          - read acknowledged this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_handshake #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_start_rd,
  input  logic              i_start_wr,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_ack,
  output logic              o_req,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_wdata,
  output logic              o_rd_done
);

  edulent_pkg::mem_state_t state_q;
  logic                    req_q;
  logic                    we_q;
  logic [ADDR_W-1:0]       addr_q;
  logic [DATA_W-1:0]       wdata_q;

  // Outputs are registered alongside the state so they change only on the
  // edges that move the FSM (and on reset).
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= edulent_pkg::MEM_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      case (state_q)
        edulent_pkg::MEM_IDLE: begin
          if (i_start_rd) begin
            state_q <= edulent_pkg::MEM_RD_WAIT;
            req_q   <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= i_addr;
          end else if (i_start_wr) begin
            state_q <= edulent_pkg::MEM_WR_WAIT;
            req_q   <= 1'b1;
            we_q    <= 1'b1;
            addr_q  <= i_addr;
            wdata_q <= i_wdata;
          end
        end
        edulent_pkg::MEM_RD_WAIT,
        edulent_pkg::MEM_WR_WAIT: begin
          if (i_ack) begin
            state_q <= edulent_pkg::MEM_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
          end
        end
        default: begin
          state_q <= edulent_pkg::MEM_IDLE;
          req_q   <= 1'b0;
          we_q    <= 1'b0;
        end
      endcase
    end
  end

  assign o_req     = req_q;
  assign o_we      = we_q;
  assign o_addr    = addr_q;
  assign o_wdata   = wdata_q;
  assign o_rd_done = (state_q == edulent_pkg::MEM_RD_WAIT) && i_ack;

endmodule : mem_handshake
`default_nettype wire

// File: rtl/transfer_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : transfer_datapath
//  Description : Register-transfer datapath (PC, SP, MA, MD, IR, A, AP,
//                output port) driven by a 4-bit command bus, with a
//                req/ack memory interface. Commands and PC/SP updates are
//                accepted only while no memory transaction is in progress.
//  Ports       : i_clk, i_rstn        - clock, async active-low reset
//                i_transfer_cmd       - register-transfer command
//                i_inc_pc, i_inc_dec_sp - PC increment, SP inc (01)/dec (10)
//                i_dst_ap             - A/AP select for commands 5, 8, A
//                i_alu_result, i_in_data - ALU result, input port
//                i_mem_ack, i_mem_rdata  - memory completion, read data
//                o_mem_*              - memory request interface
//                o_opcode, o_a, o_ap  - IR, A, AP
//                o_out, o_out_valid   - output port and update strobe
//                o_busy               - memory transaction in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module transfer_datapath #(
  parameter int                 DATA_W  = 8,
  parameter int                 ADDR_W  = 8,
  parameter logic [ADDR_W-1:0]  PC_INIT = 8'h00,
  parameter logic [ADDR_W-1:0]  SP_INIT = 8'hFF
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic [3:0]        i_transfer_cmd,
  input  logic              i_inc_pc,
  input  logic [1:0]        i_inc_dec_sp,
  input  logic              i_dst_ap,
  input  logic [DATA_W-1:0] i_alu_result,
  input  logic [DATA_W-1:0] i_in_data,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic [DATA_W-1:0] o_opcode,
  output logic [DATA_W-1:0] o_a,
  output logic [DATA_W-1:0] o_ap,
  output logic [DATA_W-1:0] o_out,
  output logic              o_out_valid,
  output logic              o_busy
);

  import edulent_pkg::*;

  // Transfers between address registers (PC/SP/MA) and data registers
  // (MD/A/AP) are direct copies, so ADDR_W and DATA_W are used equal.
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] sp_q, sp_d;
  logic [ADDR_W-1:0] ma_q, ma_d;
  logic [DATA_W-1:0] md_q, md_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] ap_q, ap_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              out_valid_q, out_valid_d;

  logic              w_start_rd;
  logic              w_start_wr;
  logic              w_rd_done;
  logic              w_busy;

  mem_handshake #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem_handshake (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .i_start_rd (w_start_rd),
    .i_start_wr (w_start_wr),
    .i_addr     (ma_q),
    .i_wdata    (md_q),
    .i_ack      (i_mem_ack),
    .o_req      (o_mem_req),
    .o_we       (o_mem_we),
    .o_addr     (o_mem_addr),
    .o_wdata    (o_mem_wdata),
    .o_rd_done  (w_rd_done)
  );

  assign w_busy = o_mem_req;

  // All command reads use the _q values, so a command that reads PC or SP
  // in the same cycle as an increment naturally sees the pre-increment value.
  always_comb begin
    pc_d        = pc_q;
    sp_d        = sp_q;
    ma_d        = ma_q;
    md_d        = md_q;
    ir_d        = ir_q;
    a_d         = a_q;
    ap_d        = ap_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    w_start_rd  = 1'b0;
    w_start_wr  = 1'b0;

    if (!w_busy) begin
      if (i_inc_pc) begin
        pc_d = pc_q + ADDR_W'(1);
      end
      case (i_inc_dec_sp)
        2'b01:   sp_d = sp_q + ADDR_W'(1);
        2'b10:   sp_d = sp_q - ADDR_W'(1);
        default: sp_d = sp_q;
      endcase

      // PC loads below override the increment applied above.
      case (transfer_cmd_t'(i_transfer_cmd))
        CMD_NOP:     ;
        CMD_MA_PC:   ma_d = pc_q;
        CMD_MEM_RD:  w_start_rd = 1'b1;
        CMD_IR_MD:   ir_d = md_q;
        CMD_MA_MD:   ma_d = md_q;
        CMD_ACC_MD:  if (i_dst_ap) ap_d = md_q; else a_d = md_q;
        CMD_MA_AP:   ma_d = ap_q;
        CMD_MA_SP:   ma_d = sp_q;
        CMD_MD_ACC:  md_d = i_dst_ap ? ap_q : a_q;
        CMD_MEM_WR:  w_start_wr = 1'b1;
        CMD_ACC_ALU: if (i_dst_ap) ap_d = i_alu_result; else a_d = i_alu_result;
        CMD_PC_MD:   pc_d = md_q;
        CMD_A_IN:    a_d = i_in_data;
        CMD_OUT_A: begin
          out_d       = a_q;
          out_valid_d = 1'b1;
        end
        CMD_PC_AP:   pc_d = ap_q;
        CMD_MD_PC:   md_d = pc_q;
        default:     ;
      endcase
    end

    // Read data lands on the ack edge; no command can be accepted then.
    if (w_rd_done) begin
      md_d = i_mem_rdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      pc_q        <= PC_INIT;
      sp_q        <= SP_INIT;
      ma_q        <= '0;
      md_q        <= '0;
      ir_q        <= '0;
      a_q         <= '0;
      ap_q        <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      sp_q        <= sp_d;
      ma_q        <= ma_d;
      md_q        <= md_d;
      ir_q        <= ir_d;
      a_q         <= a_d;
      ap_q        <= ap_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign o_opcode    = ir_q;
  assign o_a         = a_q;
  assign o_ap        = ap_q;
  assign o_out       = out_q;
  assign o_out_valid = out_valid_q;
  assign o_busy      = w_busy;

endmodule : transfer_datapath
`default_nettype wire
